// File: rtl/user_rom_streamer_pkg.sv
// Shared types and constants for the user ROM byte streamer.
// Holds the OBI configuration/struct types used by default, the FSM state
// enum and the byte-unpacking constants.
package user_rom_streamer_pkg;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
   } obi_cfg_t;

   localparam int unsigned ObiAddrWidth = 32;
   localparam int unsigned ObiDataWidth = 32;

   localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: ObiAddrWidth, DataWidth: ObiDataWidth};

   typedef struct packed {
      logic [ObiAddrWidth-1:0]   addr;
      logic                      we;
      logic [ObiDataWidth/8-1:0] be;
      logic [ObiDataWidth-1:0]   wdata;
      logic [0:0]                aid;
      logic [0:0]                a_optional;
   } rom_obi_a_chan_t;

   typedef struct packed {
      logic            req;
      rom_obi_a_chan_t a;
   } rom_obi_req_t;

   typedef struct packed {
      logic [ObiDataWidth-1:0] rdata;
      logic [0:0]              rid;
      logic                    err;
      logic [0:0]              r_optional;
   } rom_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      rom_obi_r_chan_t r;
   } rom_obi_rsp_t;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StEmit
   } state_e;

   localparam int unsigned BytesPerWord = 4;
   localparam logic [7:0]  NulByte      = 8'h00;

endpackage

// File: rtl/user_word_unpacker.sv
// Holds one 32-bit word and walks its bytes little-endian.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   load, word    : capture a new word and restart at byte 0
//   active        : owner is presenting bytes from this word
//   ready         : consumer accepts the presented byte
//   data          : byte at the current index
//   valid         : data is a presentable (non-NUL) byte
//   fire          : handshake this cycle
//   is_nul        : current byte is the NUL terminator
//   is_last       : current byte is the top byte of the word
module user_word_unpacker
   import user_rom_streamer_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load,
   input  logic [31:0] word,
   input  logic        active,
   input  logic        ready,
   output logic [7:0]  data,
   output logic        valid,
   output logic        fire,
   output logic        is_nul,
   output logic        is_last
);

   localparam int unsigned IdxWidth = $clog2(BytesPerWord);

   logic [BytesPerWord-1:0][7:0] word_q;
   logic [IdxWidth-1:0]          idx_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (load) begin
         word_q <= word;
         idx_q  <= '0;
      end else if (fire) begin
         idx_q <= idx_q + IdxWidth'(1);
      end
   end

   always_comb begin
      data    = word_q[idx_q];
      is_nul  = (data == NulByte);
      is_last = (idx_q == IdxWidth'(BytesPerWord - 1));
      // NUL bytes are never offered to the consumer
      valid   = active && !is_nul;
      fire    = valid && ready;
   end

endmodule

// File: rtl/user_rom_streamer.sv
// OBI read manager that streams a NUL-terminated string out of the user ROM.
// On start it reads consecutive words from an aligned base address and hands
// them out byte by byte (little-endian) until a NUL byte, MaxWords words, or
// an OBI error response.
// Ports:
//   clk_i, rst_ni             : clock, async active-low reset
//   start_i, base_addr_i      : run request and first word address
//   obi_req_o, obi_rsp_i      : OBI manager port towards the ROM
//   byte_o, byte_valid_o,
//   byte_ready_i              : byte stream with valid/ready handshake
//   busy_o                    : run in progress
//   done_o                    : one-cycle pulse at the end of a run
//   err_o                     : sticky OBI error flag, cleared by next start
module user_rom_streamer
   import user_rom_streamer_pkg::*;
#(
   parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
   parameter type         obi_req_t = rom_obi_req_t,
   parameter type         obi_rsp_t = rom_obi_rsp_t,
   parameter int unsigned MaxWords  = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
   output obi_req_t                    obi_req_o,
   input  obi_rsp_t                    obi_rsp_i,
   output logic [7:0]                  byte_o,
   output logic                        byte_valid_o,
   input  logic                        byte_ready_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int unsigned AddrWidth = ObiCfg.AddrWidth;
   localparam int unsigned CntWidth  = $clog2(MaxWords + 1);

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic       load;
   logic [7:0] cur_byte;
   logic       cur_valid, cur_fire, cur_nul, cur_last;
   logic       unused_in;

   assign unused_in = ^{base_addr_i[1:0], obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

   user_word_unpacker u_unpacker (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load    (load),
      .word    (obi_rsp_i.r.rdata),
      .active  (state_q == StEmit),
      .ready   (byte_ready_i),
      .data    (cur_byte),
      .valid   (cur_valid),
      .fire    (cur_fire),
      .is_nul  (cur_nul),
      .is_last (cur_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      load    = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               addr_d  = {base_addr_i[AddrWidth-1:2], 2'b00};
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (obi_rsp_i.gnt) state_d = StWait;
         end
         StWait: begin
            if (obi_rsp_i.rvalid) begin
               if (obi_rsp_i.r.err) begin
                  err_d   = 1'b1;
                  done_o  = 1'b1;
                  state_d = StIdle;
               end else begin
                  load    = 1'b1;
                  state_d = StEmit;
               end
            end
         end
         StEmit: begin
            if (cur_nul) begin
               // Terminator ends the run; rest of the word is discarded
               done_o  = 1'b1;
               state_d = StIdle;
            end else if (cur_fire && cur_last) begin
               cnt_d  = cnt_q + CntWidth'(1);
               addr_d = addr_q + AddrWidth'(BytesPerWord);
               if (cnt_d == CntWidth'(MaxWords)) begin
                  done_o  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StReq;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      obi_req_o        = '0;
      obi_req_o.req    = (state_q == StReq);
      obi_req_o.a.addr = addr_q;
      // Byte enables only while requesting so the idle bus reads all-zero
      obi_req_o.a.be   = obi_req_o.req ? 4'hF : 4'h0;
   end

   assign byte_valid_o = cur_valid;
   assign byte_o       = cur_valid ? cur_byte : 8'h00;
   assign busy_o       = (state_q != StIdle);
   assign err_o        = err_q;

endmodule

// File: tb/tb_user_rom_streamer.sv
module tb_user_rom_streamer;
   import user_rom_streamer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: MaxWords=8, instance 1: MaxWords=2
   logic         start  [2];
   logic [31:0]  base_a [2];
   rom_obi_req_t req    [2];
   rom_obi_rsp_t rsp    [2];
   logic [7:0]   byte_d [2];
   logic         bval   [2];
   logic         bready [2];
   logic         busy   [2];
   logic         done   [2];
   logic         err    [2];

   user_rom_streamer #(.MaxWords(8)) u_dut_w8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .base_addr_i(base_a[0]),
      .obi_req_o(req[0]), .obi_rsp_i(rsp[0]), .byte_o(byte_d[0]), .byte_valid_o(bval[0]),
      .byte_ready_i(bready[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
   );

   user_rom_streamer #(.MaxWords(2)) u_dut_w2 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .base_addr_i(base_a[1]),
      .obi_req_o(req[1]), .obi_rsp_i(rsp[1]), .byte_o(byte_d[1]), .byte_valid_o(bval[1]),
      .byte_ready_i(bready[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
   );

   // ROM contents (64 bytes, byte addressed, address wraps mod 64)
   logic [7:0] mem [64];

   // ROM responder: gnt gated by gnt_ok, rvalid two cycles after grant
   int          rd_cnt [2] = '{0, 0};
   int          err_on_read [2] = '{-1, -1};
   logic [31:0] gaddr [2][1024];
   logic        p1 [2], p2 [2], e1 [2], e2 [2];
   logic [31:0] a1 [2], a2 [2];
   logic        gnt_ok [2];
   logic [5:0]  ba;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            p1[i] <= 1'b0; p2[i] <= 1'b0; e1[i] <= 1'b0; e2[i] <= 1'b0;
            a1[i] <= '0;   a2[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            p1[i] <= req[i].req && rsp[i].gnt;
            p2[i] <= p1[i];
            a2[i] <= a1[i];
            e2[i] <= e1[i];
            if (req[i].req && rsp[i].gnt) begin
               a1[i] <= req[i].a.addr;
               e1[i] <= (rd_cnt[i] == err_on_read[i]);
               gaddr[i][rd_cnt[i] % 1024] <= req[i].a.addr;
               rd_cnt[i] <= rd_cnt[i] + 1;
            end
         end
      end
   end

   always_comb begin
      ba = '0;
      for (int i = 0; i < 2; i++) begin
         rsp[i] = '0;
         rsp[i].gnt = req[i].req && gnt_ok[i];
         rsp[i].rvalid = p2[i];
         if (p2[i]) begin
            ba = a2[i][5:0];
            rsp[i].r.err = e2[i];
            if (!e2[i]) rsp[i].r.rdata = {mem[ba + 6'd3], mem[ba + 6'd2], mem[ba + 6'd1], mem[ba]};
         end
      end
   end

   // Scoreboard and counters
   logic [7:0] exp_q [$];
   int n_cmp = 0;
   int n_fail = 0;
   int done_cnt [2] = '{0, 0};
   int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
   int gnt_mode = 0;   // 0: immediate grant, 1: random grant

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Input driver for ready and grant throttling
   initial begin
      bready = '{1'b1, 1'b1};
      gnt_ok = '{1'b1, 1'b1};
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            case (rdy_mode)
               0:       bready[i] = 1'b1;
               1:       bready[i] = ~bready[i];
               default: bready[i] = 1'($urandom_range(0, 1));
            endcase
            gnt_ok[i] = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: pops expected bytes on every handshake, checks hold rules
   logic       hold_v [2] = '{1'b0, 1'b0};
   logic [7:0] hold_b [2];
   logic       hold_r [2] = '{1'b0, 1'b0};
   logic [31:0] hold_a [2];

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               hold_v[i] = 1'b0;
               hold_r[i] = 1'b0;
            end else begin
               if (done[i]) done_cnt[i]++;
               if (hold_v[i]) begin
                  check("byte valid held", bval[i], 1);
                  check("byte data held", byte_d[i], hold_b[i]);
               end
               if (hold_r[i]) begin
                  check("req held", req[i].req, 1);
                  check("addr held", req[i].a.addr, hold_a[i]);
               end
               if (bval[i] && bready[i]) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL extra byte: got %02h expected none", byte_d[i]);
                  end else begin
                     logic [7:0] e;
                     e = exp_q.pop_front();
                     check("byte data", byte_d[i], e);
                  end
               end
               hold_v[i] = bval[i] && !bready[i];
               hold_b[i] = byte_d[i];
               hold_r[i] = req[i].req && !rsp[i].gnt;
               hold_a[i] = req[i].a.addr;
            end
         end
      end
   end

   // Reference model: walk words from the aligned base, stop on NUL or limit
   task automatic model(input int i, input logic [31:0] base, output int nbytes,
                        output int nreads);
      int maxw;
      logic [31:0] a;
      logic [7:0] b;
      bit stop;
      maxw = (i == 0) ? 8 : 2;
      a = {base[31:2], 2'b00};
      nbytes = 0;
      nreads = 0;
      stop = 1'b0;
      for (int w = 0; w < maxw && !stop; w++) begin
         nreads++;
         for (int k = 0; k < 4 && !stop; k++) begin
            b = mem[6'(a + 32'(4 * w + k))];
            if (b == 8'h00) stop = 1'b1;
            else begin
               exp_q.push_back(b);
               nbytes++;
            end
         end
      end
   endtask

   task automatic run(input int i, input logic [31:0] base, input bit expect_err,
                      input bit restart);
      int nbytes, nreads, rd0, d0, k, first_req, first_bv;
      bit finished, restarted;
      if (expect_err) begin
         nbytes = 0;
         nreads = 1;
      end else begin
         model(i, base, nbytes, nreads);
      end
      @(posedge clk);
      #1;
      rd0 = rd_cnt[i];
      d0 = done_cnt[i];
      base_a[i] = base;
      start[i] = 1'b1;
      k = 0;
      first_req = -1;
      first_bv = -1;
      finished = 1'b0;
      restarted = 1'b0;
      while (k < 3000 && !finished) begin
         @(negedge clk);
         if (k == 1) check("err cleared by start", err[i], 0);
         if (req[i].req && first_req < 0) first_req = k;
         if (bval[i] && first_bv < 0) first_bv = k;
         if (k > 0 && !busy[i]) finished = 1'b1;
         @(posedge clk);
         #1;
         if (restart && first_bv >= 0 && !restarted) begin
            start[i] = 1'b1;
            restarted = 1'b1;
         end else begin
            start[i] = 1'b0;
         end
         k++;
      end
      check("run finished in bound", finished, 1);
      check("bytes left unsent", exp_q.size(), 0);
      check("obi reads", rd_cnt[i] - rd0, nreads);
      check("done pulses", done_cnt[i] - d0, 1);
      check("err flag", err[i], expect_err);
      check("first addr", gaddr[i][rd0 % 1024], {base[31:2], 2'b00});
      if (gnt_mode == 0) begin
         check("req latency", first_req, 1);
         if (nbytes > 0) check("byte latency", first_bv, 4);
      end
      exp_q.delete();
   endtask

   task automatic load_id();
      string s;
      s = "T.PIIGNATO USER ROM IC";
      for (int k = 0; k < 64; k++) begin
         if (k < s.len()) mem[k] = s[k];
         else if (k == s.len()) mem[k] = 8'h00;
         else mem[k] = 8'h5A;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req"}, req[0] == '0, 1);
      check({tag, " byte"}, byte_d[0], 0);
      check({tag, " valid"}, bval[0], 0);
      check({tag, " busy"}, busy[0], 0);
      check({tag, " done"}, done[0], 0);
      check({tag, " err"}, err[0], 0);
   endtask

   initial begin
      int nb, nr, d0;
      start = '{1'b0, 1'b0};
      base_a = '{32'h0, 32'h0};
      load_id();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // ROM ID string, ready high, then ready toggling
      run(0, 32'h0, 1'b0, 1'b0);
      rdy_mode = 1;
      run(0, 32'h0, 1'b0, 1'b0);
      rdy_mode = 0;

      // Word limit of 2
      run(1, 32'h0, 1'b0, 1'b0);

      // Error on the first read, then a clean run clears err
      err_on_read[0] = rd_cnt[0];
      run(0, 32'h0, 1'b1, 1'b0);
      check("busy low after error", busy[0], 0);
      err_on_read[0] = -1;
      run(0, 32'h0, 1'b0, 1'b0);

      // Unaligned base plus a start pulse during EMIT
      run(0, 32'h7, 1'b0, 1'b1);

      // Asynchronous reset while a byte is valid
      model(0, 32'h0, nb, nr);
      d0 = done_cnt[0];
      @(posedge clk);
      #1;
      base_a[0] = 32'h0;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      for (int k = 0; k < 50 && !bval[0]; k++) @(negedge clk);
      check("valid before reset", bval[0], 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      check("no done on reset", done_cnt[0] - d0, 0);
      run(0, 32'h0, 1'b0, 1'b0);

      // Randomized contents, bases, ready and grant patterns
      for (int k = 0; k < 64; k++)
         mem[k] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int t = 0; t < 16; t++) begin
         rdy_mode = $urandom_range(0, 2);
         gnt_mode = $urandom_range(0, 1);
         run($urandom_range(0, 1), 32'($urandom_range(0, 255)), 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
